multicycle_accumulator: RTL and testbench
=========================================

Name: multicycle_accumulator

Overview:
Parametrised accumulator for the adders lab datapath. It adds, subtracts, loads or clears a DATA_WIDTH operand into a held accumulator. Arithmetic runs CHUNK_WIDTH bits per cycle behind a start/busy/done handshake, and the block reports carry and signed overflow. It sits between the run-button edge detector (start_i) and the hex display / sign LED logic.

Parameters:
DATA_WIDTH, 16, accumulator and operand width
CHUNK_WIDTH, 4, bits processed per CALC cycle; must divide DATA_WIDTH evenly (NCHUNK = DATA_WIDTH/CHUNK_WIDTH)
COUNT_WIDTH, 8, width of the completed-operation counter

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
start_i  in  1  single-cycle request pulse; sampled only in IDLE
op_i  in  2  operation, sampled with start_i: 00 add, 01 sub, 10 load, 11 clear
operand_i  in  DATA_WIDTH  operand, sampled with start_i
busy_o  out  1  high while the state is not IDLE
done_o  out  1  one-cycle pulse when a result commits
acc_o  out  DATA_WIDTH  committed accumulator value
carry_o  out  1  carry out of the last add/sub (sub: 1 = no borrow)
overflow_o  out  1  signed two's-complement overflow of the last add/sub
op_count_o  out  COUNT_WIDTH  number of committed operations, wraps modulo 2^COUNT_WIDTH

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset, on any edge with reset=1, in any state:
  - all outputs and internal registers go to 0 and the state goes to IDLE
  - an in-flight operation is discarded with no done_o pulse
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start_i=1 with add/sub:
    - latch operand B = operand_i (add) or ~operand_i (sub)
    - cin = 0 (add) or 1 (sub)
    - copy acc_o into working register A; clear chunk index; go to CALC
  - start_i=1 with load/clear:
    - acc_o <= operand_i (load) or 0 (clear)
    - carry_o <= 0, overflow_o <= 0; go to DONE
  - start_i=0: stay in IDLE.
- CALC, each cycle:
  - add chunk k of A, chunk k of B and the running carry (CHUNK_WIDTH+1-bit sum)
  - store the chunk result into the working sum register; the carry propagates to the next chunk
  - after chunk NCHUNK-1, commit on the same edge:
    - acc_o <= sum
    - carry_o <= final carry
    - overflow_o <= (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB])
    - go to DONE
- DONE: done_o=1 for exactly this cycle; op_count_o increments on entry; next state is IDLE.
- Latency:
  - add/sub: start sampled at edge 0, done_o high in the cycle after edge NCHUNK+1 (5 cycles for defaults)
  - load/clear: done_o high in the cycle after edge 1
- acc_o holds its old value throughout CALC and never shows partial sums.
- start_i while busy_o=1 (CALC or DONE) is ignored and not queued.
- op_i and operand_i changes after the sampling edge have no effect.
- Arithmetic wraps modulo 2^DATA_WIDTH.
- op_count_o wraps from all-ones to 0.

Test Plan (defaults, DATA_WIDTH=16, CHUNK_WIDTH=4):
- Reset, then idle 3 cycles -> acc_o=0x0000, carry_o=0, overflow_o=0, busy_o=0, done_o=0, op_count_o=0.
- From acc 0: add 0x0003 -> busy_o high 5 cycles; done_o pulses once; acc_o=0x0003, carry_o=0, op_count_o=1; acc_o stays 0x0000 until commit.
- Load 0xFFFF, then add 0x0001 -> acc_o=0x0000, carry_o=1, overflow_o=0. Load 0x7FFF, then add 0x0001 -> acc_o=0x8000, carry_o=0, overflow_o=1.
- Load 0x0003, then sub 0x0005 -> acc_o=0xFFFE, carry_o=0. Load 0x8000, then sub 0x0001 -> acc_o=0x7FFF, overflow_o=1, carry_o=1.
- Add 0x0010 with a second start_i (add 0x1000) 2 cycles later -> the second start is ignored; acc_o=old+0x0010; op_count_o increments by exactly 1.
- Start add, assert reset in the 3rd CALC cycle -> next cycle all outputs are 0, state is IDLE, no done_o pulse. Clear after 255 commits -> op_count_o wraps 0xFF->0x00.

Source files
------------

// File: rtl/multicycle_accumulator.sv
// multicycle_accumulator
//   Holds a DATA_WIDTH accumulator and applies add, sub, load or clear to it.
//   Add and sub run CHUNK_WIDTH bits per cycle through a narrow adder. Load and
//   clear commit in one step. Every operation goes through a start/busy/done
//   handshake.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   start_i     request pulse, sampled only while idle
//   op_i        00 add, 01 sub, 10 load, 11 clear (sampled with start_i)
//   operand_i   operand (sampled with start_i)
//   busy_o      high while an operation is in flight (CALC or DONE)
//   done_o      one-cycle pulse when a result commits
//   acc_o       committed accumulator value
//   carry_o     carry out of the last add/sub (sub: 1 = no borrow)
//   overflow_o  signed overflow of the last add/sub
//   op_count_o  committed-operation counter, wraps
module multicycle_accumulator #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned CHUNK_WIDTH = 4,
    parameter int unsigned COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic [1:0]             op_i,
    input  logic [DATA_WIDTH-1:0]  operand_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [DATA_WIDTH-1:0]  acc_o,
    output logic                   carry_o,
    output logic                   overflow_o,
    output logic [COUNT_WIDTH-1:0] op_count_o
);

    localparam int unsigned NChunk = DATA_WIDTH / CHUNK_WIDTH;
    localparam int unsigned IdxW   = (NChunk > 1) ? $clog2(NChunk) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  a_q, a_d;
    logic [DATA_WIDTH-1:0]  b_q, b_d;
    logic [DATA_WIDTH-1:0]  sum_q, sum_d;
    logic                   a_msb_q, a_msb_d;
    logic                   b_msb_q, b_msb_d;
    logic                   cin_q, cin_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]  acc_q, acc_d;
    logic                   carry_q, carry_d;
    logic                   ovf_q, ovf_d;
    logic                   done_q, done_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic [CHUNK_WIDTH:0]            chunk_sum;
    logic [DATA_WIDTH+CHUNK_WIDTH-1:0] sum_wide;
    logic [DATA_WIDTH-1:0]           sum_next;

    // A and B shift right one chunk per cycle so the adder always sees the low
    // chunk. Results shift in from the top, so after NChunk steps sum is aligned.
    assign chunk_sum = {1'b0, a_q[CHUNK_WIDTH-1:0]} + {1'b0, b_q[CHUNK_WIDTH-1:0]}
                     + {{CHUNK_WIDTH{1'b0}}, cin_q};
    assign sum_wide  = {chunk_sum[CHUNK_WIDTH-1:0], sum_q};
    assign sum_next  = sum_wide[DATA_WIDTH+CHUNK_WIDTH-1:CHUNK_WIDTH];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        cin_d   = cin_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        count_d = count_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (!op_i[1]) begin
                        // op_i[0] selects sub: B = ~operand, carry-in 1.
                        a_d     = acc_q;
                        b_d     = op_i[0] ? ~operand_i : operand_i;
                        a_msb_d = acc_q[DATA_WIDTH-1];
                        b_msb_d = op_i[0] ? ~operand_i[DATA_WIDTH-1]
                                          : operand_i[DATA_WIDTH-1];
                        cin_d   = op_i[0];
                        sum_d   = '0;
                        idx_d   = '0;
                        state_d = StCalc;
                    end else begin
                        acc_d   = op_i[0] ? '0 : operand_i;
                        carry_d = 1'b0;
                        ovf_d   = 1'b0;
                        done_d  = 1'b1;
                        count_d = count_q + COUNT_WIDTH'(1);
                        state_d = StDone;
                    end
                end
            end
            StCalc: begin
                a_d   = a_q >> CHUNK_WIDTH;
                b_d   = b_q >> CHUNK_WIDTH;
                cin_d = chunk_sum[CHUNK_WIDTH];
                sum_d = sum_next;
                idx_d = idx_q + IdxW'(1);
                if (idx_q == IdxW'(NChunk - 1)) begin
                    acc_d   = sum_next;
                    carry_d = chunk_sum[CHUNK_WIDTH];
                    ovf_d   = (a_msb_q == b_msb_q) && (sum_next[DATA_WIDTH-1] != a_msb_q);
                    done_d  = 1'b1;
                    count_d = count_q + COUNT_WIDTH'(1);
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            cin_q   <= 1'b0;
            idx_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            cin_q   <= cin_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign busy_o     = (state_q != StIdle);
    assign done_o     = done_q;
    assign acc_o      = acc_q;
    assign carry_o    = carry_q;
    assign overflow_o = ovf_q;
    assign op_count_o = count_q;

endmodule

// File: tb/tb_multicycle_accumulator.sv
// Directed bench for multicycle_accumulator at default parameters.
module tb_multicycle_accumulator;

    logic        clk;
    logic        reset;
    logic        start_i;
    logic [1:0]  op_i;
    logic [15:0] operand_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] acc_o;
    logic        carry_o;
    logic        overflow_o;
    logic [7:0]  op_count_o;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_accumulator #(
        .DATA_WIDTH (16),
        .CHUNK_WIDTH(4),
        .COUNT_WIDTH(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_i   (start_i),
        .op_i      (op_i),
        .operand_i (operand_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .acc_o     (acc_o),
        .carry_o   (carry_o),
        .overflow_o(overflow_o),
        .op_count_o(op_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and follow it until busy_o drops (sampled on negedges).
    // Operand is scrambled right after the sampling edge.
    task automatic run_op(input logic [1:0] op, input logic [15:0] opd,
                          output int busy_cyc, output int done_cnt, output int early);
        logic [15:0] pre;
        bit          fin;
        @(negedge clk);
        pre       = acc_o;
        start_i   = 1'b1;
        op_i      = op;
        operand_i = opd;
        @(negedge clk);
        start_i   = 1'b0;
        op_i      = ~op;
        operand_i = ~opd;
        busy_cyc  = 0;
        done_cnt  = 0;
        early     = 0;
        fin       = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!busy_o) begin
                fin = 1'b1;
                break;
            end
            busy_cyc++;
            if (done_o) done_cnt++;
            if (!done_o && acc_o !== pre) early++;
            @(negedge clk);
        end
        if (!fin) check_eq("op_timeout", 32'(fin), 32'd1);
    endtask

    int bc, dc, ea;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        start_i   = 1'b0;
        op_i      = 2'b00;
        operand_i = 16'h0000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_acc",   32'(acc_o),      32'h0);
        check_eq("rst_carry", 32'(carry_o),    32'h0);
        check_eq("rst_ovf",   32'(overflow_o), 32'h0);
        check_eq("rst_busy",  32'(busy_o),     32'h0);
        check_eq("rst_done",  32'(done_o),     32'h0);
        check_eq("rst_count", 32'(op_count_o), 32'h0);

        // add 3 from 0
        run_op(2'b00, 16'h0003, bc, dc, ea);
        check_eq("add3_busy",  32'(bc), 32'd5);
        check_eq("add3_done",  32'(dc), 32'd1);
        check_eq("add3_early", 32'(ea), 32'd0);
        check_eq("add3_acc",   32'(acc_o),      32'h0003);
        check_eq("add3_carry", 32'(carry_o),    32'h0);
        check_eq("add3_count", 32'(op_count_o), 32'h1);

        run_op(2'b10, 16'hFFFF, bc, dc, ea);
        check_eq("load_busy", 32'(bc), 32'd1);
        check_eq("load_done", 32'(dc), 32'd1);
        check_eq("load_acc",  32'(acc_o), 32'hFFFF);
        run_op(2'b00, 16'h0001, bc, dc, ea);
        check_eq("wrap_acc",   32'(acc_o),      32'h0000);
        check_eq("wrap_carry", 32'(carry_o),    32'h1);
        check_eq("wrap_ovf",   32'(overflow_o), 32'h0);

        run_op(2'b10, 16'h7FFF, bc, dc, ea);
        run_op(2'b00, 16'h0001, bc, dc, ea);
        check_eq("povf_acc",   32'(acc_o),      32'h8000);
        check_eq("povf_carry", 32'(carry_o),    32'h0);
        check_eq("povf_ovf",   32'(overflow_o), 32'h1);

        run_op(2'b10, 16'h0003, bc, dc, ea);
        run_op(2'b01, 16'h0005, bc, dc, ea);
        check_eq("sub_acc",   32'(acc_o),      32'hFFFE);
        check_eq("sub_carry", 32'(carry_o),    32'h0);
        check_eq("sub_ovf",   32'(overflow_o), 32'h0);

        run_op(2'b10, 16'h8000, bc, dc, ea);
        run_op(2'b01, 16'h0001, bc, dc, ea);
        check_eq("novf_acc",   32'(acc_o),      32'h7FFF);
        check_eq("novf_carry", 32'(carry_o),    32'h1);
        check_eq("novf_ovf",   32'(overflow_o), 32'h1);
        check_eq("cnt9",       32'(op_count_o), 32'd9);

        // Second start while busy must be dropped.
        run_op(2'b10, 16'h0100, bc, dc, ea);
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b00; operand_i = 16'h0010;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        start_i = 1'b1; operand_i = 16'h1000;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 20 && busy_o; i++) @(negedge clk);
        check_eq("ovl_idle",  32'(busy_o), 32'h0);
        repeat (3) @(negedge clk);
        check_eq("ovl_noq",   32'(busy_o),     32'h0);
        check_eq("ovl_acc",   32'(acc_o),      32'h0110);
        check_eq("ovl_count", 32'(op_count_o), 32'd11);

        // Reset in the third CALC cycle.
        start_i = 1'b1; op_i = 2'b00; operand_i = 16'h0005;
        @(negedge clk);
        start_i = 1'b0;
        check_eq("mid_busy", 32'(busy_o), 32'h1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("mid_acc",   32'(acc_o),      32'h0);
        check_eq("mid_busy0", 32'(busy_o),     32'h0);
        check_eq("mid_done",  32'(done_o),     32'h0);
        check_eq("mid_carry", 32'(carry_o),    32'h0);
        check_eq("mid_ovf",   32'(overflow_o), 32'h0);
        check_eq("mid_count", 32'(op_count_o), 32'h0);
        @(negedge clk);
        check_eq("mid_done2", 32'(done_o), 32'h0);

        // Counter wrap.
        for (int i = 0; i < 255; i++) run_op(2'b10, 16'(i), bc, dc, ea);
        check_eq("cnt_ff",   32'(op_count_o), 32'hFF);
        check_eq("cnt_acc",  32'(acc_o),      32'h00FE);
        run_op(2'b11, 16'hABCD, bc, dc, ea);
        check_eq("clr_busy", 32'(bc), 32'd1);
        check_eq("clr_acc",  32'(acc_o),      32'h0);
        check_eq("cnt_wrap", 32'(op_count_o), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
